boot_loader_arbiter: RTL and testbench

- Owns the data port of the 2-port RAM/MMIO memory block after reset.
- Drains a program image from the UART RX FIFO and writes it word by word into RAM.
- Holds the CPU stalled while loading.
- When the load completes, hands the data port to the CPU as a pure combinational pass-through.

---
 rtl/boot_loader_arbiter_if.sv | 41 ++++
 rtl/boot_loader_arbiter.sv | 138 +++++++++++++
 tb/tb_boot_loader_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_arbiter_if.sv
//------------------------------------------------------------------------------
// boot_loader_arbiter_if
// CPU data port, memory data port, UART RX FIFO and boot status of the loader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface boot_loader_arbiter_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_writedata;
  logic        cpu_writectrl;
  logic        cpu_readctrl;
  logic [2:0]  cpu_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic        mem_writectrl;
  logic        mem_readctrl;
  logic [2:0]  mem_funct3;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rdreq;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_error;

  modport slave (
    input  cpu_addr, cpu_writedata, cpu_writectrl, cpu_readctrl, cpu_funct3,
    input  rx_empty, rx_data,
    output mem_addr, mem_writedata, mem_writectrl, mem_readctrl, mem_funct3,
    output rx_rdreq, cpu_hold, boot_done, boot_error
  );

  modport master (
    output cpu_addr, cpu_writedata, cpu_writectrl, cpu_readctrl, cpu_funct3,
    output rx_empty, rx_data,
    input  mem_addr, mem_writedata, mem_writectrl, mem_readctrl, mem_funct3,
    input  rx_rdreq, cpu_hold, boot_done, boot_error
  );
endinterface

`default_nettype wire

// File: rtl/boot_loader_arbiter.sv
//------------------------------------------------------------------------------
// boot_loader_arbiter
// Loads a UART program image into RAM after reset, then hands the port to the CPU.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module boot_loader_arbiter #(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0008,
  parameter logic [31:0] MAX_WORDS = 32'd32768,
  parameter bit          SKIP_BOOT = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  boot_loader_arbiter_if.slave bus
);

  localparam int WIDX_W = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam state_t RESET_STATE = SKIP_BOOT ? S_DONE : S_HDR;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       n_q, n_d;
  logic              pending_q, pending_d;

  logic [31:0] w_asm;
  logic [31:0] w_idx;
  logic [31:0] w_next_idx;
  logic [31:0] w_load_addr;
  logic        w_fetch;
  logic        w_rdreq;

  // Assembly register with the byte arriving this cycle dropped into its lane.
  always_comb begin
    w_asm = asm_q;
    w_asm[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
  end

  assign w_idx       = 32'(word_idx_q);
  assign w_next_idx  = w_idx + 32'd1;
  assign w_load_addr = LOAD_BASE + (w_idx << 2);
  assign w_fetch     = (state_q == S_HDR) || (state_q == S_DATA);
  assign w_rdreq     = w_fetch && !bus.rx_empty && !pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      asm_q      <= 32'd0;
      n_q        <= 32'd0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    byte_cnt_d        = byte_cnt_q;
    word_idx_d        = word_idx_q;
    asm_d             = asm_q;
    n_d               = n_q;
    pending_d         = 1'b0;
    bus.mem_addr      = w_load_addr;
    bus.mem_writedata = asm_q;
    bus.mem_writectrl = 1'b0;
    bus.mem_readctrl  = 1'b0;
    bus.mem_funct3    = 3'b010;
    bus.rx_rdreq      = 1'b0;
    bus.cpu_hold      = 1'b1;
    bus.boot_done     = 1'b0;
    bus.boot_error    = 1'b0;

    case (state_q)
      S_HDR, S_DATA: begin
        bus.rx_rdreq = w_rdreq;
        pending_d    = w_rdreq;
        if (pending_q) begin
          asm_d      = w_asm;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_DATA) begin
              state_d = S_WRITE;
            end else if (w_asm == 32'd0) begin
              state_d = S_DONE;
            end else if (w_asm > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              n_d     = w_asm;
              state_d = S_DATA;
            end
          end
        end
      end
      S_WRITE: begin
        bus.mem_writectrl = 1'b1;
        word_idx_d        = word_idx_q + {{(WIDX_W-1){1'b0}}, 1'b1};
        state_d           = (w_next_idx == n_q) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        // Zero-latency handover: the CPU sees the memory exactly as if wired directly.
        bus.mem_addr      = bus.cpu_addr;
        bus.mem_writedata = bus.cpu_writedata;
        bus.mem_writectrl = bus.cpu_writectrl;
        bus.mem_readctrl  = bus.cpu_readctrl;
        bus.mem_funct3    = bus.cpu_funct3;
        bus.cpu_hold      = 1'b0;
        bus.boot_done     = 1'b1;
      end
      S_ERR: begin
        bus.boot_error = 1'b1;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_arbiter.sv
//------------------------------------------------------------------------------
// tb_boot_loader_arbiter
// Directed and randomized image loads checked against an image-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_boot_loader_arbiter;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_arbiter_if bif ();
  boot_loader_arbiter_if sif ();

  boot_loader_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  boot_loader_arbiter #(.SKIP_BOOT(1'b1)) dut_skip (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int vectors = 0;
  int miscompares = 0;

  bq_t         img;
  bq_t         fifo;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          gap_fixed, gap_max, gap_cnt;
  int          cycle = 0;
  int          pops, last_pop_cyc, last_wr_cyc, done_cyc, viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic r, input logic [2:0] f);
    bif.cpu_addr = a; bif.cpu_writedata = d; bif.cpu_writectrl = w;
    bif.cpu_readctrl = r; bif.cpu_funct3 = f;
    sif.cpu_addr = a; sif.cpu_writedata = d; sif.cpu_writectrl = w;
    sif.cpu_readctrl = r; sif.cpu_funct3 = f;
  endtask

  task automatic drive_cpu_random();
    drive_cpu($urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom));
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
  endtask

  // One clock: sample DUT at negedge, then model the FIFO after the rising edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    if (!bif.boot_done) begin
      if (bif.mem_readctrl !== 1'b0 || bif.mem_funct3 !== 3'b010) viol++;
      if (!bif.mem_writectrl && bif.mem_addr !== 32'h8 + 32'(4 * wr_addr.size())) viol++;
      if (bif.mem_writectrl === 1'b1) begin
        wr_addr.push_back(bif.mem_addr);
        wr_data.push_back(bif.mem_writedata);
        last_wr_cyc = cycle;
      end
    end
    if (bif.cpu_hold === bif.boot_done) viol++;
    if (bif.rx_rdreq && bif.rx_empty) viol++;
    if (bif.boot_done && done_cyc < 0) done_cyc = cycle;
    pop = bif.rx_rdreq && !bif.rx_empty;
    @(posedge clk);
    #1;
    cycle++;
    if (gap_cnt > 0) gap_cnt--;
    if (pop) begin
      bif.rx_data  = fifo.pop_front();
      pops++;
      last_pop_cyc = cycle - 1;
      gap_cnt      = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, gap_max);
    end
    drive_cpu_random();
    bif.rx_empty = (fifo.size() == 0) || (gap_cnt > 0);
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    fifo.delete();
    bif.rx_empty = 1'b1; bif.rx_data = 8'h00;
    sif.rx_empty = 1'b1; sif.rx_data = 8'h00;
    drive_cpu(32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    @(negedge clk);
    if (check) begin
      chk("rst.cpu_hold", 32'(bif.cpu_hold), 32'd1);
      chk("rst.boot_done", 32'(bif.boot_done), 32'd0);
      chk("rst.boot_error", 32'(bif.boot_error), 32'd0);
      chk("rst.rx_rdreq", 32'(bif.rx_rdreq), 32'd0);
      chk("rst.mem_wr_rd", {30'd0, bif.mem_writectrl, bif.mem_readctrl}, 32'd0);
      chk("rst.skip_hold_done", {30'd0, sif.cpu_hold, sif.boot_done}, 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Loads the global image plus a little trailing junk, then compares against the model.
  task automatic run_image(input string tag, input int gfix, input int gmax, input int stop_after);
    logic [31:0] n, exp_word;
    int          nw, exp_pops;
    bit          exp_err, finished;
    n        = {img[3], img[2], img[1], img[0]};
    exp_err  = (n > 32'd32768);
    nw       = exp_err ? 0 : int'(n);
    exp_pops = 4 + 4 * nw;
    fifo = img;
    for (int k = 0; k < 3; k++) fifo.push_back(8'($urandom));
    wr_addr.delete(); wr_data.delete();
    pops = 0; done_cyc = -1; viol = 0; last_pop_cyc = -1; last_wr_cyc = -1;
    gap_fixed = gfix; gap_max = gmax; gap_cnt = 0;
    bif.rx_empty = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (stop_after > 0 && pops >= stop_after) begin finished = 1'b1; break; end
      if (stop_after == 0 && (done_cyc >= 0 || bif.boot_error)) begin finished = 1'b1; break; end
    end
    chk({tag, ".finished"}, 32'(finished), 32'd1);
    if (stop_after > 0) return;
    repeat (4) step();
    chk({tag, ".boot_error"}, 32'(bif.boot_error), 32'(exp_err));
    chk({tag, ".boot_done"}, 32'(bif.boot_done), 32'(!exp_err));
    chk({tag, ".cpu_hold"}, 32'(bif.cpu_hold), 32'(exp_err));
    chk({tag, ".rx_rdreq"}, 32'(bif.rx_rdreq), 32'd0);
    chk({tag, ".pops"}, 32'(pops), 32'(exp_pops));
    chk({tag, ".nwrites"}, 32'(wr_addr.size()), 32'(nw));
    chk({tag, ".per_cycle_rules"}, 32'(viol), 32'd0);
    for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
      exp_word = {img[4*i+7], img[4*i+6], img[4*i+5], img[4*i+4]};
      chk($sformatf("%s.addr%0d", tag, i), wr_addr[i], 32'h8 + 32'(4 * i));
      chk($sformatf("%s.data%0d", tag, i), wr_data[i], exp_word);
    end
    if (!exp_err)
      chk({tag, ".done_timing"}, 32'(done_cyc),
          32'((nw == 0) ? last_pop_cyc + 2 : last_wr_cyc + 1));
  endtask

  task automatic check_mirror(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic r, input logic [2:0] f, input bit skip);
    drive_cpu(a, d, w, r, f);
    #1;
    if (skip) begin
      chk({tag, ".addr"}, sif.mem_addr, a);
      chk({tag, ".wdata"}, sif.mem_writedata, d);
      chk({tag, ".ctrl"}, {27'd0, sif.mem_writectrl, sif.mem_readctrl, sif.mem_funct3},
          {27'd0, w, r, f});
    end else begin
      chk({tag, ".addr"}, bif.mem_addr, a);
      chk({tag, ".wdata"}, bif.mem_writedata, d);
      chk({tag, ".ctrl"}, {27'd0, bif.mem_writectrl, bif.mem_readctrl, bif.mem_funct3},
          {27'd0, w, r, f});
    end
  endtask

  initial begin
    do_reset(1'b1);

    // Skipped boot: pass-through straight out of reset.
    chk("skip.boot_done", 32'(sif.boot_done), 32'd1);
    chk("skip.cpu_hold", 32'(sif.cpu_hold), 32'd0);
    check_mirror("skip.mirror", 32'h100, 32'hA5, 1'b1, 1'b0, 3'b010, 1'b1);

    // Two-word image, FIFO never empty.
    img.delete(); add_word(32'd2); add_word(32'h12345678); add_word(32'hDEADBEEF);
    run_image("img2", 0, 0, 0);
    check_mirror("done.mirror", 32'h100, 32'hA5, 1'b1, 1'b0, 3'b010, 1'b0);
    for (int k = 0; k < 3; k++)
      check_mirror($sformatf("done.rmirror%0d", k), $urandom, $urandom,
                   1'($urandom), 1'($urandom), 3'($urandom), 1'b0);

    // Zero-length image.
    do_reset(1'b1);
    img.delete(); add_word(32'd0);
    run_image("zero", 0, 0, 0);

    // Oversized header: sticky error, no further pops.
    do_reset(1'b1);
    img.delete(); add_word(32'h0000_8001); add_word($urandom);
    run_image("toobig", 0, 0, 0);

    // Same two-word image with 5 empty cycles between bytes.
    do_reset(1'b0);
    img.delete(); add_word(32'd2); add_word(32'h12345678); add_word(32'hDEADBEEF);
    run_image("gap5", 5, 0, 0);

    // Reset after six bytes, then the full image again.
    do_reset(1'b0);
    run_image("abort", 0, 0, 6);
    chk("abort.nwrites", 32'(wr_addr.size()), 32'd0);
    do_reset(1'b0);
    run_image("reload", 0, 0, 0);

    // Largest accepted count is not rejected and starts writing.
    do_reset(1'b0);
    img.delete(); add_word(32'd32768); add_word(32'hCAFEF00D);
    run_image("max", 0, 0, 8);
    repeat (6) step();
    chk("max.boot_error", 32'(bif.boot_error), 32'd0);
    chk("max.nwrites", 32'(wr_addr.size()), 32'd1);
    chk("max.data0", (wr_data.size() > 0) ? wr_data[0] : 32'hX, 32'hCAFEF00D);

    // Randomized images with random FIFO gaps.
    for (int t = 0; t < 5; t++) begin
      do_reset(1'b0);
      img.delete();
      add_word(32'($urandom_range(1, 4)));
      for (int i = 0; i < int'({img[3], img[2], img[1], img[0]}); i++) add_word($urandom);
      run_image($sformatf("rand%0d", t), -1, 3, 0);
    end

    // Randomized oversized headers.
    for (int t = 0; t < 2; t++) begin
      do_reset(1'b0);
      img.delete(); add_word(32'h0000_8001 + $urandom_range(0, 100000)); add_word($urandom);
      run_image($sformatf("rbad%0d", t), -1, 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
